// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S master clock controller and the
// transmitter/receiver benches.
//   state_t       controller state encoding (ST_IDLE / ST_RUN / ST_DRAIN)
//   WS_LEFT/RIGHT word-select polarity of the two channel slots
//   MIN_HALF_DIV  smallest divider accepted; keeps every SCK level >= 2 ACLK
//                 cycles so a 2-FF edge detector never misses an edge
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   localparam int unsigned MIN_HALF_DIV = 1;

endpackage

// File: rtl/i2s_master_clock_ctrl_if.sv
// i2s_master_clock_ctrl_if: bundle between the clock controller and the
// I2S transmitter.
//   sck, ws                 bit clock / word select, driven by the controller
//   mon_tvalid, mon_tready  copies of the transmitter's AXI-Stream handshake,
//                           observed by the controller for underrun counting
interface i2s_master_clock_ctrl_if;

   logic sck;
   logic ws;
   logic mon_tvalid;
   logic mon_tready;

   modport master (
      output sck,
      output ws,
      input  mon_tvalid,
      input  mon_tready
   );

   modport slave (
      input  sck,
      input  ws,
      output mon_tvalid,
      output mon_tready
   );

endinterface

// File: rtl/i2s_sck_div.sv
// i2s_sck_div: SCK half-period timer and bit-clock register.
//   clk, rst_n  clock / async active-low reset
//   load        capture div_in as the half-period divider (IDLE->RUN)
//   run         1 while the controller is busy; 0 parks sck low
//   div_in      half-period = div_in+1 clock cycles
//   sck         registered bit clock
//   toggle      1-cycle strobe: sck flips on the coming edge
//   fall        toggle while sck is high (coming 1->0 edge)
module i2s_sck_div #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div_in,
   output logic                 sck,
   output logic                 toggle,
   output logic                 fall
);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] half_cnt;

   // down-counter reloaded with div_q; terminal count 0 marks the flip,
   // giving div_q+1 cycles per SCK level
   assign toggle = run && (half_cnt == '0);
   assign fall   = toggle && sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         half_cnt <= '0;
         sck      <= 1'b0;
      end else if (load) begin
         div_q    <= div_in;
         half_cnt <= div_in;
         sck      <= 1'b0;
      end else if (!run) begin
         half_cnt <= div_q;
         sck      <= 1'b0;
      end else if (toggle) begin
         half_cnt <= div_q;
         sck      <= ~sck;
      end else begin
         half_cnt <= half_cnt - DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/i2s_master_clock_ctrl.sv
// i2s_master_clock_ctrl: master-mode SCK/WS generator for the I2S transmit
// path with clean frame-aligned start/stop and an underrun counter.
//   S_AXIS_ACLK     clock
//   S_AXIS_ARESETN  async active-low reset (release synchronised here)
//   enable          1 = run, 0 = stop at the end of the current frame
//   clk_div         SCK half-period = clk_div+1 cycles (0 treated as 1),
//                   captured only when leaving IDLE
//   underrun_clr    zeroes underrun_cnt (wins over an increment)
//   i2s             sck/ws out, mon_tvalid/mon_tready in
//   busy            state != IDLE
//   frame_tick      1-cycle pulse after each ws 1->0 transition
//   underrun_cnt    saturating count of requests left unserved at slot ends
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | clocks parked low; waits for enable, captures the divider
// ST_RUN   | free-running SCK/WS
// ST_DRAIN | enable dropped; finish the frame, stop on the right->left edge
module i2s_master_clock_ctrl
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIV_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  S_AXIS_ACLK,
   input  logic                  S_AXIS_ARESETN,
   input  logic                  enable,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   input  logic                  underrun_clr,
   i2s_master_clock_ctrl_if.master i2s,
   output logic                  busy,
   output logic                  frame_tick,
   output logic [CNT_WIDTH-1:0]  underrun_cnt
);

   localparam int BIT_W = $clog2(DATA_WIDTH);

   logic [1:0]           rst_sync;
   logic                 rst_n;
   state_t               state_q;
   state_t               state_d;
   logic                 load;
   logic [DIV_WIDTH-1:0] div_in;
   logic                 sck_w;
   logic                 toggle;
   logic                 fall;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 ws_q;
   logic                 last_bit;
   logic                 ws_toggle;
   logic                 frame_end;

   // assertion reaches every flop immediately; release waits two edges
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) rst_sync <= 2'b00;
      else                 rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign div_in = (clk_div < DIV_WIDTH'(MIN_HALF_DIV)) ? DIV_WIDTH'(MIN_HALF_DIV) : clk_div;

   i2s_sck_div #(.DIV_WIDTH(DIV_WIDTH)) u_sck_div (
      .clk    (S_AXIS_ACLK),
      .rst_n  (rst_n),
      .load   (load),
      .run    (busy),
      .div_in (div_in),
      .sck    (sck_w),
      .toggle (toggle),
      .fall   (fall)
   );

   assign busy      = (state_q != ST_IDLE);
   assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign ws_toggle = fall && last_bit;
   assign frame_end = ws_toggle && (ws_q == WS_RIGHT);
   assign i2s.sck   = sck_w;
   assign i2s.ws    = ws_q;

   always_ff @(posedge S_AXIS_ACLK or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // sck is already falling here, so it parks low with ws
            if (frame_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         ws_q       <= WS_LEFT;
         bit_cnt    <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (!busy) begin
            ws_q    <= WS_LEFT;
            bit_cnt <= '0;
         end else if (fall) begin
            if (last_bit) begin
               bit_cnt <= '0;
               ws_q    <= ~ws_q;
            end else begin
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
         end
      end
   end

   // a request still open when the slot flips means stale data is replayed
   always_ff @(posedge S_AXIS_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (underrun_clr) begin
         underrun_cnt <= '0;
      end else if (busy && ws_toggle && i2s.mon_tready && !i2s.mon_tvalid &&
                   (underrun_cnt != '1)) begin
         underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
